// File: rtl/encrypt_pkg.sv
// Shared types for the encrypt_unit front end: FSM states and the per-byte
// tag that travels alongside each byte through the unit's pipeline.
package encrypt_pkg;

    localparam int ID_W   = 1;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CFG    = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            last;
    } tag_t;

endpackage

// File: rtl/encrypt_config.svh
// Build-wide defaults for the encryption datapath.
// ENC_LATENCY is the encrypt_unit pipeline depth (en -> v) in cycles.
`ifndef ENCRYPT_CONFIG_SVH
`define ENCRYPT_CONFIG_SVH
`define ENC_LATENCY 2
`endif

// File: rtl/encrypt_tag_pipe.sv
// Tag shift register mirroring the encrypt_unit latency, plus an in-flight
// byte counter and a sticky error flag for tag/valid disagreement.
module encrypt_tag_pipe
    import encrypt_pkg::*;
#(
    parameter int PIPE_LAT = 2
)
(
    input  logic clk,
    input  logic rst,
    input  tag_t push,
    input  logic enc_v,
    output tag_t head,
    output logic drained,
    output logic err
);

    localparam int CNT_W = $clog2(PIPE_LAT + 2);

    tag_t             stage_reg [PIPE_LAT];
    logic [CNT_W-1:0] count_reg;
    logic             err_reg;

    // Shifts every cycle so the head lines up with enc_v exactly PIPE_LAT cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= push;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    // Decrement saturates at zero so a stray enc_v cannot wrap the count and block config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            case ({push.valid, enc_v})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   if (count_reg != '0) count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (enc_v != head.valid) begin
            err_reg <= 1'b1;
        end
    end

    assign head    = stage_reg[PIPE_LAT-1];
    assign drained = (count_reg == '0);
    assign err     = err_reg;

endmodule

// File: rtl/encrypt_arbiter.sv
// Round-robin scheduler sharing one encrypt_unit between two byte streams
// and a key-load port; tags each byte so outputs carry source and packet end.
`include "encrypt_config.svh"

module encrypt_arbiter
    import encrypt_pkg::*;
#(
    parameter int PIPE_LAT  = `ENC_LATENCY,
    parameter int MAX_BURST = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_key,
    output logic              cfg_ready,
    output logic              enc_en,
    output logic [DATA_W-1:0] enc_din,
    output logic              enc_cfg_en,
    output logic [DATA_W-1:0] enc_cfg_data,
    input  logic              enc_v,
    input  logic [DATA_W-1:0] enc_dout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              err
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    state_e            state_reg, state_next;
    logic [ID_W-1:0]   gnt_reg, gnt_next;
    logic [ID_W-1:0]   rr_reg, rr_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;

    logic              en_reg;
    logic [DATA_W-1:0] din_reg;
    logic [ID_W-1:0]   id_reg;
    logic              last_reg;

    logic [1:0]             valid_vec;
    logic [1:0]             last_vec;
    logic [1:0][DATA_W-1:0] data_vec;
    logic                   accept;
    logic                   drained;
    tag_t                   push_tag;
    tag_t                   head_tag;

    assign valid_vec = {req1_valid, req0_valid};
    assign last_vec  = {req1_last, req0_last};
    assign data_vec  = {req1_data, req0_data};
    assign accept    = (state_reg == STREAM) && valid_vec[gnt_reg];

    // A pending key load freezes new grants until the unit has drained, so it cannot starve.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        rr_next    = rr_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_valid) begin
                    if (drained && !en_reg) state_next = CFG;
                end else if (valid_vec[rr_reg]) begin
                    gnt_next   = rr_reg;
                    beat_next  = '0;
                    state_next = STREAM;
                end else if (valid_vec[~rr_reg]) begin
                    gnt_next   = ~rr_reg;
                    beat_next  = '0;
                    state_next = STREAM;
                end
            end
            CFG: state_next = IDLE;
            STREAM: begin
                if (accept) begin
                    beat_next = beat_reg + 1'b1;
                    if (last_vec[gnt_reg] || beat_reg == BEAT_W'(MAX_BURST - 1)) begin
                        state_next = GAP;
                        rr_next    = ~gnt_reg;
                    end
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            rr_reg    <= '0;
            beat_reg  <= '0;
            en_reg    <= 1'b0;
            din_reg   <= '0;
            id_reg    <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            rr_reg    <= rr_next;
            beat_reg  <= beat_next;
            en_reg    <= accept;
            din_reg   <= accept ? data_vec[gnt_reg] : '0;
            id_reg    <= accept ? gnt_reg : '0;
            last_reg  <= accept && last_vec[gnt_reg];
        end
    end

    assign push_tag = '{valid: en_reg, id: id_reg, last: last_reg};

    encrypt_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .push    (push_tag),
        .enc_v   (enc_v),
        .head    (head_tag),
        .drained (drained),
        .err     (err)
    );

    assign req0_ready   = (state_reg == STREAM) && (gnt_reg == ID_W'(0));
    assign req1_ready   = (state_reg == STREAM) && (gnt_reg == ID_W'(1));
    assign cfg_ready    = (state_reg == CFG);
    assign enc_cfg_en   = (state_reg == CFG);
    assign enc_cfg_data = (state_reg == CFG) ? cfg_key : '0;
    assign enc_en       = en_reg;
    assign enc_din      = din_reg;

    // Gated by the tag so bytes issued before a reset never surface as output.
    assign out_valid = enc_v && head_tag.valid;
    assign out_data  = out_valid ? enc_dout : '0;
    assign out_id    = head_tag.id;
    assign out_last  = head_tag.last;

endmodule

// File: doc/encrypt_arbiter.md
# encrypt_arbiter

Round-robin scheduler that shares one `encrypt_unit` between two byte-stream requesters and a key-configuration port. It grants bursts of bytes, drives the unit's `en`/`din` and configuration strobe, and tags every byte in flight so each output byte comes back labelled with its source and packet boundary. It sits directly in front of `encrypt_unit`; the unit's output goes through this block to the consumer.

## Interface
- `PIPE_LAT`, default `` `ENC_LATENCY `` (2): cycles from `enc_en` high to the matching `enc_v` high.
- `MAX_BURST`, default 4: maximum beats per grant before forced re-arbitration.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: requester has a byte.
- `req0_data`, `req1_data` in 8: plaintext byte.
- `req0_last`, `req1_last` in 1: byte ends the packet.
- `req0_ready`, `req1_ready` out 1: byte accepted this cycle when valid && ready.
- `cfg_valid` in 1: key-load request.
- `cfg_key` in 8: key value.
- `cfg_ready` out 1: key accepted this cycle.
- `enc_en` out 1: to unit `en`.
- `enc_din` out 8: to unit `din`.
- `enc_cfg_en` out 1: key-load strobe to unit.
- `enc_cfg_data` out 8: key to unit.
- `enc_v` in 1: from unit `v`.
- `enc_dout` in 8: from unit `dout`.
- `out_valid` out 1: ciphertext byte valid; no backpressure.
- `out_data` out 8: ciphertext byte.
- `out_id` out 1: source requester.
- `out_last` out 1: end of packet.
- `err` out 1: sticky tag/valid mismatch.

## Operation
- FSM states: IDLE, CFG, STREAM, GAP.
- IDLE arbitration, priority order: (1) `cfg_valid` and in-flight count == 0 and `enc_en` == 0 -> CFG; (2) round-robin between valid requesters, starting from the one not granted last -> STREAM with `gnt` set; (3) stay IDLE.
- CFG (1 cycle): `cfg_ready`=1, `enc_cfg_en`=1, `enc_cfg_data`=`cfg_key`; then IDLE.
- STREAM: `reqN_ready`=1 only for `gnt`=N. Beat counter counts accepted beats. Leave to GAP when accepting a beat with `last`, or the MAX_BURST-th beat. Invalid cycles do not end the grant.
- GAP (1 cycle, no ready): bubble, then IDLE. The round-robin pointer updates on GAP entry.
- A packet cut by MAX_BURST resumes at the requester's next grant. `out_last` follows only the real `last`.
- A pending config waits through streaming and pipeline drain, so no output byte mixes keys. Config cannot starve: CFG outranks requesters once drained.
- Tag pipe: PIPE_LAT-deep shift of {valid,id,last}, pushed with `enc_en`. `out_valid`=`enc_v`, `out_data`=`enc_dout`, `out_id`/`out_last` from tag head.
- In-flight counter, width clog2(PIPE_LAT+2): +1 on `enc_en`, −1 on `enc_v`, both at once -> unchanged.
- `err` sets on `enc_v` with tag head invalid, or tag head valid without `enc_v`. Cleared only by reset.

## Timing
- Reset (async, any state): FSM=IDLE, RR pointer favours req0, counters and tags cleared. All outputs 0, including `enc_din`, `enc_cfg_data` and `err`. A packet partially accepted before reset is dropped; its in-flight bytes produce no `out_valid`.
- `enc_en`/`enc_din` are registered: a beat accepted in cycle N drives `enc_en` in cycle N+1. `out_valid` follows in cycle N+1+PIPE_LAT.
- Grant latency: `reqN_valid` seen in IDLE at cycle N -> `ready` in cycle N+1. Per-burst overhead is 2 cycles (GAP + IDLE).
- Back-to-back accepted beats give back-to-back `enc_en`.
- `ready` depends only on state, never combinationally on `valid`.
- `cfg_valid` and `reqN_valid` together in IDLE with pipeline empty: CFG wins.

## Structure
- Package `encrypt_pkg`: FSM state enum, tag struct {valid,id,last}, ID width constant.
- Default latency macro `ENC_LATENCY` lives in `encrypt_config.svh`.
- Sub-module `encrypt_tag_pipe`: parameterised tag shift register plus in-flight counter and `err` logic.

## Test plan
- Reset mid-STREAM (req0 sent 2 of 3 bytes) -> all outputs 0 immediately. No `out_valid` for the dropped bytes. Next grant goes to req0.
- Only req0: 3 bytes 0x11,0x22,0x33, last on 0x33 -> `enc_en` on 3 consecutive cycles. Three `out_valid` with `out_id`=0 at accept+1+PIPE_LAT; `out_last` only on the third.
- Both requesters stream 6-byte packets, MAX_BURST=4 -> grant order req0(4), req1(4), req0(2), req1(2). A 2-cycle bubble between bursts; `out_id` sequence matches.
- `cfg_valid` with key 0xA5 raised mid-burst -> `cfg_ready` held 0 until the burst ends and the pipeline drains. Then one cycle of `enc_cfg_en` with `enc_cfg_data`=0xA5, before the next grant.
- Requester drops `valid` for 3 cycles mid-burst -> grant held and beat count unchanged. No `enc_en` in those cycles.
- Force a spurious `enc_v` with the pipeline empty -> `err`=1 and stays 1 until reset.
